stack_data_addr_unit: RTL and testbench
=======================================

# stack_data_addr_unit

Parametrised data/stack address unit for the processor's data memory. It translates data-segment offsets into physical addresses inside a configurable data window, with modulo wrap-around. It also owns the stack pointer for a downward-growing stack placed directly above the data window, with push/pop/reload operations and sticky overflow/underflow detection. It sits between the decode/execute stage and the data-memory address port; all address outputs are registered.

## Interface
- ADDR_W, 8, address width in bits
- DATA_BASE, 128, first physical address of the data window
- DATA_SIZE, 96, data window size in bytes; the window is DATA_BASE..DATA_BASE+DATA_SIZE-1
- STACK_LO, DATA_BASE+DATA_SIZE, lowest stack address
- STACK_HI, 2**ADDR_W-1, highest stack address; SP reset value
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- op_valid  in  1  operation request this cycle
- op  in  2  0 = DATA, 1 = PUSH, 2 = POP, 3 = RELOAD
- addr_in  in  ADDR_W  data offset (DATA) or new SP value (RELOAD); ignored for PUSH/POP
- flag_clr  in  1  clears stack_ovf and stack_unf
- addr_out  out  ADDR_W  physical address of the accepted operation
- addr_valid  out  1  addr_out valid; one-cycle pulse per accepted DATA/PUSH/POP
- sp_out  out  ADDR_W  current stack pointer
- wrap_evt  out  1  one-cycle pulse: DATA offset was >= DATA_SIZE and wrapped
- stack_ovf  out  1  sticky: PUSH on full stack or out-of-range RELOAD
- stack_unf  out  1  sticky: POP on empty stack

## Operation
- Reset values: addr_out = DATA_BASE, addr_valid = 0, sp_out = STACK_HI, wrap_evt = 0, stack_ovf = 0, stack_unf = 0.
- SP points to the next free slot. The stack is empty when SP == STACK_HI and full when SP == STACK_LO-1.
- DATA: addr_out = DATA_BASE + (addr_in mod DATA_SIZE); addr_valid = 1; wrap_evt = (addr_in >= DATA_SIZE). SP is unchanged.
- PUSH, not full: addr_out = SP; SP <= SP-1; addr_valid = 1.
- PUSH, full: addr_valid = 0; SP is unchanged; stack_ovf <= 1.
- POP, not empty: addr_out = SP+1; SP <= SP+1; addr_valid = 1.
- POP, empty: addr_valid = 0; SP is unchanged; stack_unf <= 1.
- RELOAD with STACK_LO-1 <= addr_in <= STACK_HI: SP <= addr_in; addr_valid = 0.
- RELOAD outside that range: the write is ignored and stack_ovf <= 1.
- op_valid = 0: addr_valid = 0 and wrap_evt = 0; addr_out holds its last value.
- flag_clr and a new error in the same cycle: the set wins, so the flag remains 1.
- All arithmetic is ADDR_W-bit unsigned. The modulo uses no divider; it is a compare/subtract chain of ceil(2**ADDR_W/DATA_SIZE)-1 stages.
- Elaboration-time check: DATA_BASE+DATA_SIZE <= STACK_LO <= STACK_HI, and STACK_LO >= 1.

## Timing
- One operation per cycle, with no stall or back-pressure. Back-to-back PUSH/POP use the SP updated by the previous cycle.
- Latency is 1 cycle: an operation sampled at edge N shows its addr_out/addr_valid/wrap_evt/flags after edge N. sp_out shows the new SP after the same edge.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge. The first operation is accepted on the first rising edge after rst deasserts.

## Structure
- Shared package sdau_pkg holds:
  - op encodings OP_DATA, OP_PUSH, OP_POP, OP_RELOAD
  - default constants for DATA_BASE, DATA_SIZE and stack bounds, shared with the memory map
- One combinational sub-module, data_offset_wrap. Parameters: ADDR_W, DATA_SIZE. Inputs: offset. Outputs: reduced offset, wrapped flag.
- The top level holds the SP register, flag registers and output registers.

## Test plan
- Reset, then DATA with addr_in = 0, 95, 96, 200 -> addr_out = 128, 223, 128 (wrap_evt = 1), 136 (wrap_evt = 1), each with addr_valid after 1 cycle.
- 32 consecutive PUSH from reset -> addr_out = 255 down to 224, final sp_out = 223. A 33rd PUSH -> addr_valid = 0, sp_out stays 223, stack_ovf = 1.
- POP from reset -> addr_valid = 0 and stack_unf = 1. Then PUSH, POP -> addr_out = 255, 255, and sp_out returns to 255.
- RELOAD 240 -> sp_out = 240. RELOAD 100 -> sp_out stays 240 and stack_ovf = 1. flag_clr together with PUSH on full -> stack_ovf remains 1.
- flag_clr alone -> both flags 0 next cycle. op_valid = 0 -> addr_valid = 0 and addr_out holds.
- Assert rst asynchronously between edges mid-PUSH sequence -> sp_out = 255, flags = 0, addr_out = 128 immediately.

Source files
------------

// File: rtl/stack_data_addr_unit_pkg.sv
// Shared definitions for the data/stack address unit: operation encodings
// and the default memory-map constants used by the unit and its neighbours.
package sdau_pkg;

  // Operation codes presented by decode/execute
  typedef enum logic [1:0] {
    OP_DATA   = 2'd0,
    OP_PUSH   = 2'd1,
    OP_POP    = 2'd2,
    OP_RELOAD = 2'd3
  } sdau_op_e;

  // Default memory map: data window followed directly by the stack
  localparam int SDAU_ADDR_W    = 8;
  localparam int SDAU_DATA_BASE = 128;
  localparam int SDAU_DATA_SIZE = 96;
  localparam int SDAU_STACK_LO  = SDAU_DATA_BASE + SDAU_DATA_SIZE;
  localparam int SDAU_STACK_HI  = (2 ** SDAU_ADDR_W) - 1;

endpackage

// File: rtl/stack_data_addr_unit_if.sv
// Request/response bundle between the execute stage and the address unit.
// master = requester (execute stage), slave = the address unit itself.
interface stack_data_addr_unit_if
  import sdau_pkg::*;
#(
  parameter int ADDR_W = SDAU_ADDR_W
);
  logic              op_valid;
  sdau_op_e          op;
  logic [ADDR_W-1:0] addr_in;
  logic              flag_clr;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic [ADDR_W-1:0] sp_out;
  logic              wrap_evt;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output op_valid, op, addr_in, flag_clr,
    input  addr_out, addr_valid, sp_out, wrap_evt, stack_ovf, stack_unf
  );

  modport slave (
    input  op_valid, op, addr_in, flag_clr,
    output addr_out, addr_valid, sp_out, wrap_evt, stack_ovf, stack_unf
  );
endinterface

// File: rtl/stack_data_addr_unit_data_offset_wrap.sv
// Reduces a data offset modulo DATA_SIZE without a divider, using a short
// chain of conditional subtractions. The chain length is the worst case
// number of times DATA_SIZE fits into the full address range.
module data_offset_wrap #(
  parameter int ADDR_W    = 8,
  parameter int DATA_SIZE = 96
) (
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] reduced,
  output logic              wrapped
);
  localparam int                STAGES = ((2 ** ADDR_W) + DATA_SIZE - 1) / DATA_SIZE - 1;
  localparam logic [ADDR_W-1:0] SIZE_C = ADDR_W'(DATA_SIZE);

  logic [ADDR_W-1:0] rem;

  // Compare/subtract chain producing offset mod DATA_SIZE
  always_comb begin
    rem = offset;
    for (int i = 0; i < STAGES; i++) begin
      if (rem >= SIZE_C) begin
        rem = rem - SIZE_C;
      end
    end
    reduced = rem;
    wrapped = (offset >= SIZE_C);
  end
endmodule

// File: rtl/stack_data_addr_unit.sv
// Data/stack address unit. Maps data offsets into the data window with
// wrap-around and owns the stack pointer of a downward-growing stack that
// sits directly above the data window. All outputs are registered.
module stack_data_addr_unit
  import sdau_pkg::*;
#(
  parameter int ADDR_W    = SDAU_ADDR_W,
  parameter int DATA_BASE = SDAU_DATA_BASE,
  parameter int DATA_SIZE = SDAU_DATA_SIZE,
  parameter int STACK_LO  = DATA_BASE + DATA_SIZE,
  parameter int STACK_HI  = (2 ** ADDR_W) - 1
) (
  input logic                  clk,
  input logic                  rst,
  stack_data_addr_unit_if.slave bus
);
  localparam logic [ADDR_W-1:0] DATA_BASE_C = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] STACK_HI_C  = ADDR_W'(STACK_HI);
  localparam logic [ADDR_W-1:0] FULL_SP_C   = ADDR_W'(STACK_LO - 1);
  localparam logic [ADDR_W-1:0] ONE_C       = ADDR_W'(1);

  // Memory map must be ordered and the stack must fit inside the address space
  if (!((DATA_BASE + DATA_SIZE <= STACK_LO) && (STACK_LO <= STACK_HI) &&
        (STACK_LO >= 1) && (STACK_HI <= (2 ** ADDR_W) - 1) && (DATA_SIZE >= 1)))
  begin : g_bad_map
    $error("stack_data_addr_unit: inconsistent memory map parameters");
  end

  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              addr_valid_q, addr_valid_d;
  logic              wrap_evt_q, wrap_evt_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              stack_ovf_q, stack_ovf_d;
  logic              stack_unf_q, stack_unf_d;

  logic [ADDR_W-1:0] data_off;
  logic              data_wrapped;
  logic              stack_full;
  logic              stack_empty;
  logic              reload_ok;

  data_offset_wrap #(
    .ADDR_W   (ADDR_W),
    .DATA_SIZE(DATA_SIZE)
  ) u_wrap (
    .offset (bus.addr_in),
    .reduced(data_off),
    .wrapped(data_wrapped)
  );

  assign stack_full  = (sp_q == FULL_SP_C);
  assign stack_empty = (sp_q == STACK_HI_C);
  // Compared one bit wider so a stack top at the very end of memory stays a real compare
  assign reload_ok   = ({1'b0, bus.addr_in} >= {1'b0, FULL_SP_C}) &&
                       ({1'b0, bus.addr_in} <= {1'b0, STACK_HI_C});

  // Decode the requested operation into next address, SP and sticky flags
  always_comb begin
    addr_out_d   = addr_out_q;
    addr_valid_d = 1'b0;
    wrap_evt_d   = 1'b0;
    sp_d         = sp_q;
    stack_ovf_d  = stack_ovf_q & ~bus.flag_clr;
    stack_unf_d  = stack_unf_q & ~bus.flag_clr;
    if (bus.op_valid) begin
      case (bus.op)
        OP_DATA: begin
          addr_out_d   = DATA_BASE_C + data_off;
          addr_valid_d = 1'b1;
          wrap_evt_d   = data_wrapped;
        end
        OP_PUSH: begin
          if (stack_full) begin
            stack_ovf_d = 1'b1;
          end else begin
            addr_out_d   = sp_q;
            sp_d         = sp_q - ONE_C;
            addr_valid_d = 1'b1;
          end
        end
        OP_POP: begin
          if (stack_empty) begin
            stack_unf_d = 1'b1;
          end else begin
            addr_out_d   = sp_q + ONE_C;
            sp_d         = sp_q + ONE_C;
            addr_valid_d = 1'b1;
          end
        end
        OP_RELOAD: begin
          if (reload_ok) begin
            sp_d = bus.addr_in;
          end else begin
            stack_ovf_d = 1'b1;
          end
        end
        default: begin
          addr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output, stack pointer and flag registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_out_q   <= DATA_BASE_C;
      addr_valid_q <= 1'b0;
      wrap_evt_q   <= 1'b0;
      sp_q         <= STACK_HI_C;
      stack_ovf_q  <= 1'b0;
      stack_unf_q  <= 1'b0;
    end else begin
      addr_out_q   <= addr_out_d;
      addr_valid_q <= addr_valid_d;
      wrap_evt_q   <= wrap_evt_d;
      sp_q         <= sp_d;
      stack_ovf_q  <= stack_ovf_d;
      stack_unf_q  <= stack_unf_d;
    end
  end

  assign bus.addr_out   = addr_out_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.wrap_evt   = wrap_evt_q;
  assign bus.sp_out     = sp_q;
  assign bus.stack_ovf  = stack_ovf_q;
  assign bus.stack_unf  = stack_unf_q;
endmodule

// File: tb/tb_stack_data_addr_unit.sv
// Scoreboard bench for the data/stack address unit. The driver issues
// operations and queues the expected outputs from a depth-based stack
// model; a separate monitor pops and compares after each clock edge.
module tb_stack_data_addr_unit;
  import sdau_pkg::*;

  localparam int DATA_BASE = SDAU_DATA_BASE;
  localparam int DATA_SIZE = SDAU_DATA_SIZE;
  localparam int STACK_LO  = SDAU_STACK_LO;
  localparam int STACK_HI  = SDAU_STACK_HI;
  localparam int CAPACITY  = STACK_HI - STACK_LO + 1;

  typedef struct {
    int due;
    int vld;
    int addr;
    int wrap;
    int sp;
    int ovf;
    int unf;
  } exp_t;

  logic clk;
  logic rst;
  int   cycle;
  int   total;
  int   bad;
  exp_t q[$];

  // Reference model state: stack is tracked as an occupancy count
  int depth;
  int m_addr;
  int m_ovf;
  int m_unf;

  stack_data_addr_unit_if #(.ADDR_W(SDAU_ADDR_W)) bus ();

  stack_data_addr_unit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp expectations
  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  end

  task automatic cmp(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0d want=%0d at cycle %0d", name, got, want, cycle);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("addr_valid", int'(bus.addr_valid), e.vld);
    cmp("addr_out",   int'(bus.addr_out),   e.addr);
    cmp("wrap_evt",   int'(bus.wrap_evt),   e.wrap);
    cmp("sp_out",     int'(bus.sp_out),     e.sp);
    cmp("stack_ovf",  int'(bus.stack_ovf),  e.ovf);
    cmp("stack_unf",  int'(bus.stack_unf),  e.unf);
  endtask

  task automatic modelReset();
    depth  = 0;
    m_addr = DATA_BASE;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  function automatic exp_t resetExp();
    exp_t e;
    e.due  = 0;
    e.vld  = 0;
    e.addr = DATA_BASE;
    e.wrap = 0;
    e.sp   = STACK_HI;
    e.ovf  = 0;
    e.unf  = 0;
    return e;
  endfunction

  task automatic modelStep(input bit v, input int op, input int a, input bit clr);
    exp_t e;
    int   err_o;
    int   err_u;
    int   vld;
    int   wrap;
    err_o = 0;
    err_u = 0;
    vld   = 0;
    wrap  = 0;
    if (v) begin
      case (op)
        0: begin
          m_addr = DATA_BASE + (a % DATA_SIZE);
          vld    = 1;
          wrap   = (a >= DATA_SIZE) ? 1 : 0;
        end
        1: begin
          if (depth == CAPACITY) err_o = 1;
          else begin
            m_addr = STACK_HI - depth;
            depth  = depth + 1;
            vld    = 1;
          end
        end
        2: begin
          if (depth == 0) err_u = 1;
          else begin
            depth  = depth - 1;
            m_addr = STACK_HI - depth;
            vld    = 1;
          end
        end
        default: begin
          if (a >= STACK_LO - 1 && a <= STACK_HI) depth = STACK_HI - a;
          else err_o = 1;
        end
      endcase
    end
    m_ovf  = (err_o != 0 || (m_ovf != 0 && !clr)) ? 1 : 0;
    m_unf  = (err_u != 0 || (m_unf != 0 && !clr)) ? 1 : 0;
    e.due  = cycle + 1;
    e.vld  = vld;
    e.addr = m_addr;
    e.wrap = wrap;
    e.sp   = STACK_HI - depth;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    q.push_back(e);
  endtask

  task automatic applyStimulus(input bit v, input int op, input int a, input bit clr);
    logic [1:0] op2;
    op2 = 2'(op);
    @(posedge clk);
    #1;
    bus.op_valid = v;
    bus.op       = sdau_op_e'(op2);
    bus.addr_in  = 8'(a);
    bus.flag_clr = clr;
    modelStep(v, op, a, clr);
  endtask

  // Monitor: compares every expectation that has come due after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cycle) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Driver: directed plan, randomized traffic, then asynchronous reset
  initial begin
    int r_op;
    int r_a;
    total = 0;
    bad   = 0;
    bus.op_valid = 1'b0;
    bus.op       = OP_DATA;
    bus.addr_in  = '0;
    bus.flag_clr = 1'b0;
    modelReset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 checkOutput(resetExp());
    #10 rst = 1'b0;

    // Data window mapping including wrap
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 95, 0);
    applyStimulus(1, 0, 96, 0);
    applyStimulus(1, 0, 200, 0);
    applyStimulus(1, 0, 255, 0);

    // Fill the stack, then one push too many
    for (int i = 0; i < 33; i++) applyStimulus(1, 1, 0, 0);

    // Empty the stack via reload, pop on empty, then push/pop
    applyStimulus(1, 3, 255, 0);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);

    // Reload in and out of range, boundaries, clear vs new error
    applyStimulus(1, 3, 240, 0);
    applyStimulus(1, 3, 100, 0);
    applyStimulus(1, 3, 222, 0);
    applyStimulus(1, 3, 223, 0);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 7, 0);
    applyStimulus(0, 0, 50, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) r_a = int'($urandom_range(215, 255));
      else r_a = int'($urandom_range(0, 255));
      applyStimulus(($urandom_range(0, 7) != 0), r_op, r_a,
                    ($urandom_range(0, 7) == 0));
    end

    // Set a sticky flag, then reset asynchronously in the middle of pushes
    applyStimulus(1, 3, 255, 1);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    #6;
    rst = 1'b1;
    q.delete();
    #1;
    checkOutput(resetExp());
    bus.op_valid = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 97, 0);
    applyStimulus(0, 0, 0, 0);

    // Let the monitor drain, with a bound
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad   = bad + 1;
      total = total + 1;
      $display("[TB] FAIL drain got=%0d want=0 pending expectations", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
